// File: rtl/my_cic_pkg.sv
// my_cic_pkg: constants shared by the CIC interpolator and decimator.
// Holds defaults, error-bit indices, clog2 and register-width helpers.
package my_cic_pkg;

  localparam int CIC_NUM_STAGES = 4;
  localparam int CIC_MAX_RATE   = 160;
  localparam int CIC_DATA_WIDTH = 19;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_FWD      = 1;

  function automatic int clog2(input longint v);
    longint x;
    int r;
    x = v - 1;
    r = 0;
    while (x > 0) begin
      x = x >> 1;
      r++;
    end
    return r;
  endfunction

  // Bit growth of an N-stage CIC at the largest ratio.
  function automatic int growth(input int stages, input int max_rate);
    longint p;
    p = 1;
    for (int i = 1; i < stages; i++) p = p * longint'(max_rate);
    return clog2(p) + stages;
  endfunction

  localparam int GROWTH = growth(CIC_NUM_STAGES, CIC_MAX_RATE);
  localparam int WIDTH  = CIC_DATA_WIDTH + GROWTH;

endpackage

// File: rtl/my_cic_comb_chain.sv
// my_cic_comb_chain: NUM_STAGES differentiators at the input rate.
// Ports: clk, reset, en (advance delays), din, dout = c[NUM_STAGES].
module my_cic_comb_chain
  import my_cic_pkg::*;
#(
  parameter int NUM_STAGES = CIC_NUM_STAGES,
  parameter int WIDTH      = 45
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] c  [NUM_STAGES+1];
  logic [WIDTH-1:0] dl [NUM_STAGES];

  always_comb begin
    c[0] = din;
    for (int k = 0; k < NUM_STAGES; k++) begin
      c[k+1] = c[k] - dl[k];
    end
  end

  assign dout = c[NUM_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) dl[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < NUM_STAGES; k++) dl[k] <= c[k];
    end
  end

endmodule

// File: rtl/my_cic_interp.sv
// my_cic_interp: CIC interpolator, comb at input rate, integrators at R x.
// Ports: rate/rate_div/gain, in_* and out_* valid/ready; MY_CIC_INTERP_SAT_EN saturates out.
module my_cic_interp
  import my_cic_pkg::*;
#(
  parameter int NUM_STAGES = CIC_NUM_STAGES,
  parameter int MAX_RATE   = CIC_MAX_RATE,
  parameter int DATA_WIDTH = CIC_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rate,
  input  logic [3:0]            rate_div,
  input  logic [4:0]            gain,
  input  logic [1:0]            in_error,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_error,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int GW = growth(NUM_STAGES, MAX_RATE);
  localparam int W  = DATA_WIDTH + GW;
  localparam logic [7:0] RMAX = 8'(MAX_RATE);

  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [1:0]            hold_err;
  logic [7:0]            phase;
  logic [7:0]            r_lat;
  logic [7:0]            r_eff;
  logic                  started;
  logic                  can_load;
  logic                  at_p0;
  logic                  step;
  logic                  consume;
  logic                  accept;
  logic                  underrun;
  logic [W-1:0]          comb_in;
  logic [W-1:0]          comb_out;
  logic [W-1:0]          u;
  logic [W-1:0]          integ [NUM_STAGES];
  logic [DATA_WIDTH-1:0] out_next;
  int                    sh_i;

  assign can_load = ~out_valid | out_ready;
  assign at_p0    = (phase == 8'd0);
  assign step     = can_load & (~at_p0 | hold_full);
  assign consume  = step & at_p0;
  assign in_ready = ~hold_full | consume;
  assign accept   = in_valid & in_ready;
  assign underrun = can_load & at_p0 & ~hold_full & started;

  always_comb begin
    r_eff = rate;
    if (rate == 8'd0) r_eff = 8'd1;
    else if (rate > RMAX) r_eff = RMAX;
  end

  always_comb begin
    sh_i = int'(rate_div) * (NUM_STAGES - 1) + 8 - int'(gain);
    if (sh_i < 0) sh_i = 0;
  end

  // Hold register: a consume and a new accept in one cycle keep it full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_err  <= '0;
      started   <= 1'b0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
        hold_err  <= in_error;
        started   <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end
    end
  end

  // R is latched only at phase 0, so a rate change waits for the period end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= 8'd0;
      r_lat <= 8'd1;
    end else if (step) begin
      if (at_p0) begin
        r_lat <= r_eff;
        phase <= (r_eff == 8'd1) ? 8'd0 : 8'd1;
      end else if (phase == r_lat - 8'd1) begin
        phase <= 8'd0;
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end

  assign comb_in = {{GW{hold_data[DATA_WIDTH-1]}}, hold_data};

  my_cic_comb_chain #(
    .NUM_STAGES (NUM_STAGES),
    .WIDTH      (W)
  ) u_comb (
    .clk   (clk),
    .reset (reset),
    .en    (consume),
    .din   (comb_in),
    .dout  (comb_out)
  );

  // Zero-stuffing: the comb output enters only on the phase-0 step.
  assign u = at_p0 ? comb_out : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) integ[k] <= '0;
    end else if (step) begin
      integ[0] <= integ[0] + u;
      for (int k = 1; k < NUM_STAGES; k++) begin
        integ[k] <= integ[k] + integ[k-1];
      end
    end
  end

`ifdef MY_CIC_INTERP_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic signed [W-1:0] shifted;
  logic                fits;
  assign shifted  = $signed(integ[NUM_STAGES-1]) >>> sh_i;
  assign fits     = (&shifted[W-1:DATA_WIDTH-1]) | ~(|shifted[W-1:DATA_WIDTH-1]);
  assign out_next = fits ? shifted[DATA_WIDTH-1:0]
                  : (shifted[W-1] ? SAT_MIN : SAT_MAX);
`else
  assign out_next = DATA_WIDTH'($signed(integ[NUM_STAGES-1]) >>> sh_i);
`endif

  // Underrun flag tracks every idle load slot, so it clears on the next step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_error <= '0;
    end else if (step) begin
      out_data                <= out_next;
      out_valid               <= 1'b1;
      out_error[ERR_UNDERRUN] <= 1'b0;
      if (at_p0) out_error[ERR_FWD] <= |hold_err;
    end else if (can_load) begin
      out_valid               <= 1'b0;
      out_error[ERR_UNDERRUN] <= underrun;
    end
  end

endmodule

// File: tb/tb_my_cic_interp.sv
// tb_my_cic_interp: table rows, scoreboard stream, stall, reset, rate change.
// Expected outputs come from a boxcar^N convolution model of the interpolator.
module tb_my_cic_interp;
  import my_cic_pkg::*;

  localparam int DW = 19;
  localparam int NS = 4;
`ifdef MY_CIC_INTERP_SAT_EN
  localparam int SAT_EXP = 262143;
`else
  localparam int SAT_EXP = -16;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rate;
  logic [3:0]    rate_div;
  logic [4:0]    gain;
  logic [1:0]    in_error;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic [1:0]    out_error;
  logic          out_valid;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  my_cic_interp #(
    .NUM_STAGES (NS),
    .MAX_RATE   (160),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rate      (rate),
    .rate_div  (rate_div),
    .gain      (gain),
    .in_error  (in_error),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_data  (out_data),
    .out_error (out_error),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    err;
  } exp_t;

  typedef struct {
    int rate;
    int rd;
    int g;
    int din;
    int steady;
  } row_t;

  exp_t          sb[$];
  longint        xs[$];
  logic          xe[$];
  longint        h_q[$];
  int            r_m;
  int            sh_m;
  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  bit            bp_en = 1'b0;
  int            n_out = 0;
  logic [DW-1:0] last_data;
  logic [DW-1:0] first_data;
  exp_t          mon_e;
  row_t          tbl[8];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic build_h(input int r);
    longint t[$];
    h_q.delete();
    h_q.push_back(1);
    repeat (NS) begin
      t.delete();
      for (int i = 0; i < h_q.size() + r - 1; i++) t.push_back(0);
      for (int i = 0; i < h_q.size(); i++)
        for (int j = 0; j < r; j++) t[i+j] += h_q[i];
      h_q = t;
    end
  endtask

  task automatic setup_model(input int r, input int rd, input int g);
    r_m = (r == 0) ? 1 : (r > 160) ? 160 : r;
    sh_m = rd * (NS - 1) + 8 - g;
    if (sh_m < 0) sh_m = 0;
    build_h(r_m);
    xs.delete();
    xe.delete();
    sb.delete();
    n_out = 0;
  endtask

  // Output of step n: zero-stuffed inputs through boxcar^N, N-step delay.
  function automatic exp_t model_out(input int n);
    exp_t   e;
    longint acc;
    int     k;
    acc = 0;
    for (int i = 0; i < h_q.size(); i++) begin
      k = n - NS - i;
      if (k >= 0 && k % r_m == 0 && k / r_m < xs.size())
        acc += h_q[i] * xs[k / r_m];
    end
    acc = acc >>> sh_m;
`ifdef MY_CIC_INTERP_SAT_EN
    if (acc > 262143) acc = 262143;
    else if (acc < -262144) acc = -262144;
`endif
    e.data = acc[DW-1:0];
    e.err  = {xe[n / r_m], 1'b0};
    return e;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic [1:0] e);
    bit acc;
    int guard;
    in_data  = d;
    in_error = e;
    in_valid = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 2000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no in_ready expected accept");
    end else begin
      xs.push_back(longint'($signed(d)));
      xe.push_back(|e);
      for (int n = (xs.size() - 1) * r_m; n < xs.size() * r_m; n++)
        sb.push_back(model_out(n));
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // A transfer happens at the next edge when valid and ready are both high.
  always @(negedge clk) begin
    if (mon_en && !reset && out_valid && out_ready) begin
      n_out++;
      last_data = out_data;
      if (n_out == 1) first_data = out_data;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL extra_out: got data %0d expected no output",
                 $signed(out_data));
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_error !== mon_e.err) begin
          errors++;
          $display("FAIL stream_out %0d: got %0d err %b expected %0d err %b",
                   n_out, $signed(out_data), out_error,
                   $signed(mon_e.data), mon_e.err);
        end
      end
    end
  end

  initial begin
    int e0;
    int bad;
    int p[$];
    bit chg;

    tbl[0] = '{16, 4, 8, 1000, 1000};
    tbl[1] = '{16, 4, 9, 1000, 2000};
    tbl[2] = '{16, 4, 0, 1000, 3};
    tbl[3] = '{5, 2, 8, -1000, -1954};
    tbl[4] = '{0, 0, 8, 777, 777};
    tbl[5] = '{200, 7, 8, 100, 195};
    tbl[6] = '{1, 0, 12, 1234, 1234};
    tbl[7] = '{16, 4, 12, 262143, SAT_EXP};

    rate = 8'd16;
    rate_div = 4'd4;
    gain = 5'd8;
    in_valid = 1'b0;
    in_data = '0;
    in_error = '0;

    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_error", out_error, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_no_underrun", out_error, 0);
    chk("idle_out_valid", out_valid, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      rate = 8'(tbl[i].rate);
      rate_div = 4'(tbl[i].rd);
      gain = 5'(tbl[i].g);
      setup_model(tbl[i].rate, tbl[i].rd, tbl[i].g);
      mon_en = 1'b1;
      for (int k = 0; k < 8; k++) send(DW'(tbl[i].din), 2'b00);
      drain();
      chk($sformatf("steady_row%0d", i), longint'($signed(last_data)),
          tbl[i].steady);
    end

    do_reset();
    rate = 8'd16;
    rate_div = 4'd4;
    gain = 5'd8;
    setup_model(16, 4, 8);
    mon_en = 1'b1;
    bp_en = 1'b1;
    for (int k = 0; k < 12; k++) send(DW'($urandom), 2'($urandom));
    bp_en = 1'b0;
    for (int k = 0; k < 3; k++) send(DW'($urandom), 2'b00);
    e0 = 0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_error[0]) begin
        e0++;
        if (out_valid) bad++;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (e0 < 20) begin
      errors++;
      $display("FAIL underrun_pulses: got %0d cycles expected at least 20", e0);
    end
    chk("underrun_with_valid", bad, 0);
    for (int k = 0; k < 4; k++) send(DW'($urandom), 2'($urandom));
    drain();
    chk("stream_count", n_out, 19 * 16);

    do_reset();
    setup_model(16, 4, 8);
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) send(DW'(5000), 2'b00);
    repeat (10) @(posedge clk);
    #1;
    mon_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_error", out_error, 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    setup_model(16, 4, 8);
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) send(DW'(5000), 2'b01);
    drain();
    chk("first_after_reset", longint'($signed(first_data)), 0);
    chk("post_reset_count", n_out, 48);

    do_reset();
    rate = 8'd16;
    in_data = DW'(0);
    in_error = 2'b00;
    in_valid = 1'b1;
    chg = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) p.push_back(c);
      @(posedge clk);
      #1;
      if (p.size() >= 4 && !chg && c >= p[3] + 3) begin
        rate = 8'd5;
        chg = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (p.size() < 7) begin
      checks++;
      errors++;
      $display("FAIL rate_pulses: got %0d in_ready pulses expected 7", p.size());
    end else begin
      chk("in_ready_period_a", p[2] - p[1], 16);
      chk("in_ready_period_b", p[3] - p[2], 16);
      chk("rate_change_finish", p[4] - p[3], 16);
      chk("rate_new_a", p[5] - p[4], 5);
      chk("rate_new_b", p[6] - p[5], 5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
